// File: rtl/ram_master.sv
// ram_master: bus initiator for the shared 8-bit ram bus.
//   Takes single read/write requests on a valid/ready port and runs a two-phase
//   transfer (address phase, then data phase) with enable/rw. Read data comes
//   back on a one-cycle rsp_valid strobe. Every output is driven from a register.
// Ports:
//   clock, n_reset          clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake; accept on valid && ready
//   req_rw/addr/wdata       request fields (1 = write), latched on accept
//   rsp_valid/rsp_rdata     read completion strobe and data (data holds)
//   enable, rw              ram control
//   bus                     shared tri-state bus, master side
module ram_master #(
  parameter int TURNAROUND = 1   // 1: one released cycle after a read
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       enable,
  output logic       rw,
  inout  wire  [7:0] bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;

  state_t     state, state_nxt;
  logic       lat_rw, lat_rw_nxt;
  logic [7:0] lat_addr, lat_addr_nxt;
  logic [7:0] lat_wdata, lat_wdata_nxt;
  logic       drive, drive_nxt;
  logic [7:0] drive_data, drive_data_nxt;
  logic       enable_nxt, rw_nxt, ready_nxt;
  logic       accept;

  assign accept = req_valid && req_ready;

  // Outputs are computed from the *next* state and next latched fields so
  // they can be registered without adding a cycle of latency.
  always_comb begin
    state_nxt     = state;
    lat_rw_nxt    = lat_rw;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    if (accept) begin
      lat_rw_nxt    = req_rw;
      lat_addr_nxt  = req_addr;
      lat_wdata_nxt = req_wdata;
    end
    case (state)
      IDLE: if (accept) state_nxt = ADDR;
      ADDR: state_nxt = DATA;
      // A write's data phase also accepts, giving 2-cycle write throughput.
      DATA: if (lat_rw) state_nxt = accept ? ADDR : IDLE;
            else        state_nxt = (TURNAROUND != 0) ? TURN : IDLE;
      TURN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    enable_nxt     = (state_nxt == ADDR) || (state_nxt == DATA);
    rw_nxt         = enable_nxt && lat_rw_nxt;
    // Master drives only the address phase and the data phase of a write.
    drive_nxt      = (state_nxt == ADDR) || ((state_nxt == DATA) && lat_rw_nxt);
    drive_data_nxt = (state_nxt == ADDR) ? lat_addr_nxt : lat_wdata_nxt;
    ready_nxt      = (state_nxt == IDLE) || ((state_nxt == DATA) && lat_rw_nxt);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      drive      <= 1'b0;
      drive_data <= '0;
      enable     <= 1'b0;
      rw         <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      lat_rw     <= lat_rw_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wdata  <= lat_wdata_nxt;
      drive      <= drive_nxt;
      drive_data <= drive_data_nxt;
      enable     <= enable_nxt;
      rw         <= rw_nxt;
      req_ready  <= ready_nxt;
      // Read data phase ends on this edge: sample whatever the ram drives,
      // unknowns included.
      rsp_valid  <= (state == DATA) && !lat_rw;
      if ((state == DATA) && !lat_rw) rsp_rdata <= bus;
    end
  end

  // Tri-state buffer onto the shared bus.
  assign bus = drive ? drive_data : 8'bz;

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed bench for ram_master with a behavioural ram on the
// shared bus. A probe driver puts 8'hC3 on the bus when the bench wants to
// prove both the master and the ram have released it: any other driver
// corrupts the value.
module tb_ram_master;
  logic       clock = 1'b0;
  logic       n_reset;
  logic       req_valid, req_ready, req_rw;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       enable, rw;
  wire  [7:0] bus;
  logic       probe_en;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ram_master #(.TURNAROUND(1)) dut (
    .clock(clock), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .enable(enable), .rw(rw), .bus(bus)
  );

  // Behavioural ram: first enabled cycle is the address phase, the next is
  // data; phases alternate while enable stays high.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic       phase_data = 1'b0;
  logic [7:0] ram_addr = 8'h00;

  always @(posedge clock) begin
    if (!enable) phase_data <= 1'b0;
    else if (!phase_data) begin
      ram_addr   <= bus;
      phase_data <= 1'b1;
    end else begin
      if (rw) mem[ram_addr] <= bus;
      phase_data <= 1'b0;
    end
  end

  assign bus = (enable && !rw && phase_data) ? mem[ram_addr] : 8'bz;
  assign bus = probe_en ? 8'hC3 : 8'bz;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_released(input string tag);
    probe_en = 1'b1;
    #1;
    chk(tag, bus, 8'hC3);
    probe_en = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic request(input logic w, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_rw = w; req_addr = a; req_wdata = d;
  endtask

  initial begin
    n_reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; probe_en = 1'b0;
    @(negedge clock); @(negedge clock);

    // reset state
    chk("rst_ready", {7'b0, req_ready}, 8'h01);
    chk("rst_enable", {7'b0, enable}, 8'h00);
    chk("rst_rw", {7'b0, rw}, 8'h00);
    chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk_released("rst_bus");

    // single write 10 <- 15, reset released mid-cycle
    n_reset = 1'b1;
    request(1'b1, 8'd10, 8'd15);
    step();                                      // ADDR
    chk("wr_addr_enable", {7'b0, enable}, 8'h01);
    chk("wr_addr_rw", {7'b0, rw}, 8'h01);
    chk("wr_addr_bus", bus, 8'd10);
    chk("wr_addr_ready", {7'b0, req_ready}, 8'h00);
    req_valid = 1'b0;
    step();                                      // DATA
    chk("wr_data_enable", {7'b0, enable}, 8'h01);
    chk("wr_data_bus", bus, 8'd15);
    chk("wr_data_ready", {7'b0, req_ready}, 8'h01);
    step();                                      // IDLE
    chk("wr_idle_enable", {7'b0, enable}, 8'h00);
    chk("wr_idle_ready", {7'b0, req_ready}, 8'h01);
    chk("wr_mem10", mem[10], 8'd15);
    chk("wr_no_rsp", {7'b0, rsp_valid}, 8'h00);

    // read 10, wdata field set to a value that would be visible if driven
    request(1'b0, 8'd10, 8'hF0);
    step();                                      // ADDR
    chk("rd_addr_enable", {7'b0, enable}, 8'h01);
    chk("rd_addr_rw", {7'b0, rw}, 8'h00);
    chk("rd_addr_bus", bus, 8'd10);
    chk("rd_addr_ready", {7'b0, req_ready}, 8'h00);
    req_valid = 1'b0;
    step();                                      // DATA, ram drives
    chk("rd_data_bus", bus, 8'd15);
    chk("rd_data_ready", {7'b0, req_ready}, 8'h00);
    chk("rd_data_rsp", {7'b0, rsp_valid}, 8'h00);
    step();                                      // TURN
    chk("rd_rsp_valid", {7'b0, rsp_valid}, 8'h01);
    chk("rd_rsp_rdata", rsp_rdata, 8'd15);
    chk("turn_enable", {7'b0, enable}, 8'h00);
    chk("turn_ready", {7'b0, req_ready}, 8'h00);
    chk_released("turn_bus");
    request(1'b1, 8'h30, 8'h66);                 // read followed by write
    step();                                      // IDLE, accept at next edge
    chk("rw_idle_enable", {7'b0, enable}, 8'h00);
    chk("rw_idle_ready", {7'b0, req_ready}, 8'h01);
    chk("rd_rsp_strobe_end", {7'b0, rsp_valid}, 8'h00);
    chk("rd_rdata_hold", rsp_rdata, 8'd15);
    chk_released("rw_idle_bus");
    step();                                      // ADDR
    chk("rw_addr_bus", bus, 8'h30);
    req_valid = 1'b0;
    step();                                      // DATA
    chk("rw_data_bus", bus, 8'h66);
    step();
    chk("rw_mem30", mem[8'h30], 8'h66);
    chk("rw_no_rsp", {7'b0, rsp_valid}, 8'h00);

    // back-to-back writes; fields changed during ADDR become the second request
    request(1'b1, 8'd3, 8'hA5);
    step();                                      // ADDR 3
    chk("b2b_a1_enable", {7'b0, enable}, 8'h01);
    chk("b2b_a1_bus", bus, 8'd3);
    request(1'b1, 8'd4, 8'h5A);
    step();                                      // DATA 3
    chk("b2b_d1_enable", {7'b0, enable}, 8'h01);
    chk("b2b_d1_bus", bus, 8'hA5);
    chk("b2b_d1_ready", {7'b0, req_ready}, 8'h01);
    step();                                      // ADDR 4
    chk("b2b_a2_enable", {7'b0, enable}, 8'h01);
    chk("b2b_a2_bus", bus, 8'd4);
    req_valid = 1'b0;
    step();                                      // DATA 4
    chk("b2b_d2_enable", {7'b0, enable}, 8'h01);
    chk("b2b_d2_bus", bus, 8'h5A);
    step();
    chk("b2b_end_enable", {7'b0, enable}, 8'h00);
    chk("b2b_mem3", mem[3], 8'hA5);
    chk("b2b_mem4", mem[4], 8'h5A);

    // request fields change after acceptance
    request(1'b1, 8'h40, 8'h11);
    step();                                      // ADDR
    chk("stab_addr_bus", bus, 8'h40);
    req_valid = 1'b0; req_addr = 8'h41; req_wdata = 8'h22; req_rw = 1'b0;
    step();                                      // DATA
    chk("stab_data_bus", bus, 8'h11);
    chk("stab_data_rw", {7'b0, rw}, 8'h01);
    step();
    chk("stab_mem40", mem[8'h40], 8'h11);
    chk("stab_mem41", mem[8'h41], 8'h00);
    chk("stab_no_rsp", {7'b0, rsp_valid}, 8'h00);

    // reset in the data phase of a write
    request(1'b1, 8'd20, 8'h77);
    step();                                      // ADDR
    req_valid = 1'b0;
    step();                                      // DATA
    chk("rstw_data_bus", bus, 8'h77);
    n_reset = 1'b0;
    #1;
    chk("rstw_enable", {7'b0, enable}, 8'h00);
    chk("rstw_rw", {7'b0, rw}, 8'h00);
    chk("rstw_ready", {7'b0, req_ready}, 8'h01);
    chk_released("rstw_bus");
    step();
    chk("rstw_mem20", mem[20], 8'h00);
    chk("rstw_rsp", {7'b0, rsp_valid}, 8'h00);
    n_reset = 1'b1;

    // read after reset
    request(1'b0, 8'd4, 8'h00);
    step();                                      // ADDR
    req_valid = 1'b0;
    step();                                      // DATA
    step();                                      // TURN
    chk("post_rst_rsp_valid", {7'b0, rsp_valid}, 8'h01);
    chk("post_rst_rdata", rsp_rdata, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
